riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/riscv_lsu_load_align.sv | 40 ++++
 rtl/riscv_lsu.sv | 117 +++++++++++
 tb/tb_riscv_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared load/store definitions.
//   LDST_*      : access size encodings driven by the decoder (B/H/W/BU/HU).
//   lsu_state_t : load/store unit FSM states.
//   ldst_legal  : 1 when the size is known and the address is naturally aligned.
//   ldst_be     : byte-enable pattern for a size and a byte offset.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  function automatic logic ldst_legal(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      LDST_B, LDST_BU: ok = 1'b1;
      LDST_H, LDST_HU: ok = ~off[0];
      LDST_W:          ok = (off == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// riscv_lsu_load_align -- combinational load lane select and extension.
//   size_i : access size (LDST_* encoding)
//   off_i  : byte offset of the access within the word
//   rd_i   : raw memory read word
//   data_o : right-aligned, sign/zero-extended load result
module riscv_lsu_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = rd_i[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane_byte[off_i];
  // Halfwords are only legal at offsets 0 and 2, so off_i[1] picks the half.
  assign sel_half = off_i[1] ? rd_i[31:16] : rd_i[15:0];

  always_comb begin
    data_o = rd_i;
    case (size_i)
      LDST_B:  data_o = {{24{sel_byte[7]}}, sel_byte};
      LDST_BU: data_o = {24'h000000, sel_byte};
      LDST_H:  data_o = {{16{sel_half[15]}}, sel_half};
      LDST_HU: data_o = {16'h0000, sel_half};
      default: data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu -- single-outstanding load/store unit between core and memory.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   core_req_i/we_i      : access request, 1 = store
//   core_size_i          : LDST_* size, core_addr_i byte address
//   core_wd_i            : right-aligned store data
//   core_rd_o            : aligned/extended load data (valid when BUSY and ready)
//   core_stall_o         : hold the core pipeline
//   lsu_exc_o            : one-cycle pulse on misaligned address or illegal size
//   mem_req_o/we_o/be_o  : memory request, write enable, byte enables
//   mem_addr_o, mem_wd_o : word address, lane-replicated store data
//   mem_rd_i, mem_ready_i: memory read word and response strobe
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_exc_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_reg, state_next;
  logic [2:0]  size_reg;
  logic [1:0]  off_reg;

  logic        access_legal;
  logic        issue;
  logic        req_int, stall_int, exc_int;

  assign access_legal = ldst_legal(core_size_i, core_addr_i[1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      size_reg  <= LDST_B;
      off_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        size_reg <= core_size_i;
        off_reg  <= core_addr_i[1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_int    = 1'b0;
    stall_int  = 1'b0;
    exc_int    = 1'b0;
    issue      = 1'b0;
    if (state_reg == IDLE) begin
      if (core_req_i) begin
        if (access_legal) begin
          req_int    = 1'b1;
          stall_int  = 1'b1;
          issue      = 1'b1;
          state_next = BUSY;
        end else begin
          exc_int = 1'b1;
        end
      end
    end else begin
      req_int   = 1'b1;
      stall_int = ~mem_ready_i;
      if (mem_ready_i) begin
        state_next = IDLE;
      end
    end
  end

  // The state register alone does not silence the outputs while reset is held:
  // a pending core request would otherwise still show through in IDLE.
  assign mem_req_o    = rst_ni & req_int;
  assign core_stall_o = rst_ni & stall_int;
  assign lsu_exc_o    = rst_ni & exc_int;

  // The core holds its inputs while stalled, so the memory-side fields can be
  // taken straight from them in both states.
  assign mem_we_o   = mem_req_o & core_we_i;
  assign mem_be_o   = mem_req_o ? ldst_be(core_size_i, core_addr_i[1:0]) : 4'b0000;
  assign mem_addr_o = {core_addr_i[31:2], 2'b00};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
      always_comb begin
        mem_wd_o[8*gi +: 8] = core_wd_i[8*gi +: 8];
        case (core_size_i)
          LDST_B, LDST_BU: mem_wd_o[8*gi +: 8] = core_wd_i[7:0];
          LDST_H, LDST_HU: mem_wd_o[8*gi +: 8] = core_wd_i[8*(gi%2) +: 8];
          default:         mem_wd_o[8*gi +: 8] = core_wd_i[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  // Extraction uses the copies captured at issue, not the live core inputs.
  riscv_lsu_load_align u_load_align (
    .size_i (size_reg),
    .off_i  (off_reg),
    .rd_i   (mem_rd_i),
    .data_o (core_rd_o)
  );

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_exc_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .lsu_exc_o    (lsu_exc_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // One complete access: request cycle, 'waits' BUSY cycles without ready,
  // then one BUSY cycle with ready. Leaves ready high; the caller moves on.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rdw,
                        output logic [31:0] rd_got, output int stall_cnt, output int req_cnt,
                        output logic [3:0] be_got, output logic [31:0] wd_got,
                        output logic we_got, output logic [31:0] addr_got);
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    #1;
    be_got    = mem_be_o;
    wd_got    = mem_wd_o;
    we_got    = mem_we_o;
    addr_got  = mem_addr_o;
    stall_cnt = int'(core_stall_o);
    req_cnt   = int'(mem_req_o);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      #1;
      stall_cnt += int'(core_stall_o);
      req_cnt   += int'(mem_req_o);
    end
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    mem_rd_i    = rdw;
    #1;
    rd_got     = core_rd_o;
    stall_cnt += int'(core_stall_o);
    req_cnt   += int'(mem_req_o);
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t loads [8];
  vec_t stores [5];
  logic [2:0]  ill_size [5];
  logic [31:0] ill_addr [5];

  logic [31:0] rd_got, wd_got, addr_got;
  logic [3:0]  be_got;
  logic        we_got;
  int          stall_cnt, req_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // size, addr, memory word, expected core_rd_o, expected byte enables
    loads[0] = '{LDST_B,  32'h103, 32'h80AABBCC, 32'hFFFFFF80, 4'b1000};
    loads[1] = '{LDST_BU, 32'h103, 32'h80AABBCC, 32'h00000080, 4'b1000};
    loads[2] = '{LDST_B,  32'h101, 32'h80AABBCC, 32'hFFFFFFBB, 4'b0010};
    loads[3] = '{LDST_BU, 32'h100, 32'h80AABBCC, 32'h000000CC, 4'b0001};
    loads[4] = '{LDST_H,  32'h102, 32'h80AABBCC, 32'hFFFF80AA, 4'b1100};
    loads[5] = '{LDST_HU, 32'h102, 32'h80AABBCC, 32'h000080AA, 4'b1100};
    loads[6] = '{LDST_H,  32'h200, 32'h12348001, 32'hFFFF8001, 4'b0011};
    loads[7] = '{LDST_HU, 32'h200, 32'h12348001, 32'h00008001, 4'b0011};
    // size, addr, store data, expected mem_wd_o, expected byte enables
    stores[0] = '{LDST_H, 32'h202, 32'h1234ABCD, 32'hABCDABCD, 4'b1100};
    stores[1] = '{LDST_B, 32'h201, 32'h000000EF, 32'hEFEFEFEF, 4'b0010};
    stores[2] = '{LDST_W, 32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111};
    stores[3] = '{LDST_H, 32'h200, 32'h0000BEEF, 32'hBEEFBEEF, 4'b0011};
    stores[4] = '{LDST_B, 32'h203, 32'h11223344, 32'h44444444, 4'b1000};
    ill_size[0] = LDST_W;  ill_addr[0] = 32'h101;
    ill_size[1] = 3'd3;    ill_addr[1] = 32'h100;
    ill_size[2] = LDST_H;  ill_addr[2] = 32'h203;
    ill_size[3] = 3'd6;    ill_addr[3] = 32'h100;
    ill_size[4] = LDST_HU; ill_addr[4] = 32'h101;

    rst_ni      = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;

    // Outputs held quiet in reset, even with a request pending.
    #2;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
    core_req_i  = 1'b1;
    core_size_i = 3'd3;
    #1;
    chk("rst_exc_illegal", {31'd0, lsu_exc_o}, 32'd0);
    core_size_i = LDST_W;
    core_addr_i = 32'h100;
    #1;
    chk("rst_req_legal", {31'd0, mem_req_o}, 32'd0);

    // Idle with stray ready and store flag set: nothing on the memory side.
    @(negedge clk_i);
    rst_ni      = 1'b1;
    core_req_i  = 1'b0;
    core_we_i   = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    chk("idle_req", {31'd0, mem_req_o}, 32'd0);
    chk("idle_we", {31'd0, mem_we_o}, 32'd0);
    chk("idle_be", {28'd0, mem_be_o}, 32'd0);
    chk("idle_stall", {31'd0, core_stall_o}, 32'd0);

    // LW with ready three cycles after the request.
    access(1'b0, LDST_W, 32'h100, 32'h0, 2, 32'hDEADBEEF,
           rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
    chk("lw_be", {28'd0, be_got}, 32'h0000000F);
    chk("lw_addr", addr_got, 32'h00000100);
    chk("lw_we", {31'd0, we_got}, 32'd0);
    chk("lw_stall_cycles", stall_cnt, 32'd3);
    chk("lw_req_cycles", req_cnt, 32'd4);
    chk("lw_rd", rd_got, 32'hDEADBEEF);
    idle_cycle();
    #1;
    chk("lw_after_req", {31'd0, mem_req_o}, 32'd0);
    chk("lw_after_stall", {31'd0, core_stall_o}, 32'd0);

    foreach (loads[i]) begin
      access(1'b0, loads[i].size, loads[i].addr, 32'h0, i % 3, loads[i].data,
             rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
      chk($sformatf("load%0d_rd", i), rd_got, loads[i].exp_data);
      chk($sformatf("load%0d_be", i), {28'd0, be_got}, {28'd0, loads[i].exp_be});
    end

    foreach (stores[i]) begin
      access(1'b1, stores[i].size, stores[i].addr, stores[i].data, i % 2, 32'h0,
             rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
      chk($sformatf("store%0d_wd", i), wd_got, stores[i].exp_data);
      chk($sformatf("store%0d_be", i), {28'd0, be_got}, {28'd0, stores[i].exp_be});
      chk($sformatf("store%0d_we", i), {31'd0, we_got}, 32'd1);
      chk($sformatf("store%0d_addr", i), addr_got, {stores[i].addr[31:2], 2'b00});
    end

    // Load result follows the offset/size captured at issue, not the live inputs.
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = LDST_B;
    core_addr_i = 32'h101;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    core_size_i = LDST_W;
    core_addr_i = 32'h103;
    mem_rd_i    = 32'h80AABBCC;
    mem_ready_i = 1'b1;
    #1;
    chk("regoff_rd", core_rd_o, 32'hFFFFFFBB);
    chk("busy_exc", {31'd0, lsu_exc_o}, 32'd0);
    chk("busy_req", {31'd0, mem_req_o}, 32'd1);
    idle_cycle();

    foreach (ill_size[i]) begin
      @(negedge clk_i);
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = ill_size[i];
      core_addr_i = ill_addr[i];
      mem_ready_i = 1'b0;
      #1;
      chk($sformatf("ill%0d_exc", i), {31'd0, lsu_exc_o}, 32'd1);
      chk($sformatf("ill%0d_req", i), {31'd0, mem_req_o}, 32'd0);
      chk($sformatf("ill%0d_stall", i), {31'd0, core_stall_o}, 32'd0);
      idle_cycle();
      #1;
      chk($sformatf("ill%0d_exc_pulse", i), {31'd0, lsu_exc_o}, 32'd0);
    end

    // Back-to-back LW then SW, both ready in the first BUSY cycle.
    access(1'b0, LDST_W, 32'h300, 32'h0, 0, 32'h11111111,
           rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
    chk("b2b_lw_rd", rd_got, 32'h11111111);
    chk("b2b_lw_stall", stall_cnt, 32'd1);
    chk("b2b_lw_req", req_cnt, 32'd2);
    access(1'b1, LDST_W, 32'h304, 32'h22222222, 0, 32'h0,
           rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
    chk("b2b_sw_we", {31'd0, we_got}, 32'd1);
    chk("b2b_sw_stall", stall_cnt, 32'd1);
    chk("b2b_sw_req", req_cnt, 32'd2);
    idle_cycle();

    // Reset asserted in the middle of a BUSY access.
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h100;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("midrst_busy_req", {31'd0, mem_req_o}, 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_stall", {31'd0, core_stall_o}, 32'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    core_req_i  = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    chk("postrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("postrst_stall", {31'd0, core_stall_o}, 32'd0);
    @(negedge clk_i);
    #1;
    chk("postrst_stray_req", {31'd0, mem_req_o}, 32'd0);
    access(1'b0, LDST_BU, 32'h101, 32'h0, 1, 32'h80AABBCC,
           rd_got, stall_cnt, req_cnt, be_got, wd_got, we_got, addr_got);
    chk("postrst_lbu_rd", rd_got, 32'h000000BB);
    chk("postrst_lbu_stall", stall_cnt, 32'd2);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
